// File: rtl/hamming_enc_seq.sv
// hamming_enc_seq: stand-alone sequencer for the SECDED (16,11) encode job.
// Reads NUM_MSG 11-bit messages (byte pairs from SRC_BASE), computes the
// Hamming parity bits p8/p4/p2/p1 plus overall parity p0, and writes the
// 16-bit codewords as byte pairs from DST_BASE. Raises done when finished.
// Optional build macro: HAMMING_SEQ_MEM_ARB_EN adds mem_req/mem_gnt so the
// memory port can be shared; without it the port is always considered granted.
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
`ifdef HAMMING_SEQ_MEM_ARB_EN
  output logic          mem_req,
  input  logic          mem_gnt,
`endif
  output logic          done
);

  typedef enum logic [2:0] {
    RD_LO = 3'd0,
    RD_HI = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [7:0]    r_lo;
  logic [2:0]    r_hi;
  logic          r_done;

  logic          w_gnt;
  logic [11:1]   w_d;
  logic [4:0]    w_par;
  logic          w_p8, w_p4, w_p2, w_p1, w_p0;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;
  logic          w_unused;

  // Parity bits {p8,p4,p2,p1,p0} for message bits d[11:1].
  function automatic logic [4:0] hamming_par(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
    return {p8, p4, p2, p1, p0};
  endfunction

`ifdef HAMMING_SEQ_MEM_ARB_EN
  assign w_gnt = mem_gnt;
`else
  assign w_gnt = 1'b1;
`endif

  // The upper bits of the high source byte carry no message data.
  assign w_unused = ^mem_rd_data[7:3];

  assign w_d   = {r_hi, r_lo};
  assign w_par = hamming_par(w_d);
  assign w_p8  = w_par[4];
  assign w_p4  = w_par[3];
  assign w_p2  = w_par[2];
  assign w_p1  = w_par[1];
  assign w_p0  = w_par[0];

  // Byte offset of the current message pair; wraps modulo 2^AW.
  assign w_off = AW'({r_idx, 1'b0});
  assign w_src = AW'(SRC_BASE) + w_off;
  assign w_dst = AW'(DST_BASE) + w_off;

  assign done = r_done;

  // Memory-port outputs decoded from the current state; quiet while in reset.
  always_comb begin
    mem_addr    = AW'(SRC_BASE);
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    if (reset) begin
      mem_addr  = AW'(SRC_BASE);
      mem_wr_en = 1'b0;
    end else begin
      case (r_state)
        RD_LO: mem_addr = w_src;
        RD_HI: mem_addr = w_src + AW'(1);
        WR_LO: begin
          mem_addr    = w_dst;
          mem_wr_en   = w_gnt;
          mem_wr_data = {w_d[4:2], w_p4, w_d[1], w_p2, w_p1, w_p0};
        end
        WR_HI: begin
          mem_addr    = w_dst + AW'(1);
          mem_wr_en   = w_gnt;
          mem_wr_data = {w_d[11:5], w_p8};
        end
        FIN:     mem_addr = AW'(DST_BASE);
        default: mem_addr = AW'(SRC_BASE);
      endcase
    end
  end

`ifdef HAMMING_SEQ_MEM_ARB_EN
  // Request the shared port whenever the job still has accesses to make.
  always_comb begin
    mem_req = 1'b0;
    if (reset) begin
      mem_req = 1'b0;
    end else begin
      mem_req = (r_state != FIN);
    end
  end
`endif

  // Sequencer: read lo, read hi, write lo, write hi per message; each step
  // only advances in a granted cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RD_LO;
      r_idx   <= 4'd0;
      r_lo    <= 8'h00;
      r_hi    <= 3'b000;
      r_done  <= 1'b0;
    end else if (w_gnt) begin
      case (r_state)
        RD_LO: begin
          r_lo    <= mem_rd_data;
          r_state <= RD_HI;
        end
        RD_HI: begin
          r_hi    <= mem_rd_data[2:0];
          r_state <= WR_LO;
        end
        WR_LO: r_state <= WR_HI;
        WR_HI: begin
          if (r_idx == 4'(NUM_MSG - 1)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= RD_LO;
          end
        end
        FIN: begin
          r_state <= FIN;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= RD_LO;
          r_idx   <= 4'd0;
          r_done  <= 1'b0;
        end
      endcase
    end else begin
      r_state <= r_state;
      r_idx   <= r_idx;
      r_lo    <= r_lo;
      r_hi    <= r_hi;
      r_done  <= r_done;
    end
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench for hamming_enc_seq. The expected codeword is built the
// textbook way: data bits fill the non-power-of-two positions 3..15, each
// parity at position 2^b covers all positions with bit b set, and bit 0 is the
// overall parity. Expected port activity is derived from a count of granted
// cycles (four per message).
module tb_hamming_enc_seq;
  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;
  localparam int TOT = 4 * N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
  logic       gnt = 1'b1;
  logic       mem_req;
  logic       ld_en = 1'b0;

  logic [7:0]  mem [0:255];
  logic [7:0]  img [0:255];
  logic [10:0] msg [0:N-1];
  int          g = 0;
  int          strobes = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  hamming_enc_seq #(.NUM_MSG(N), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
`ifdef HAMMING_SEQ_MEM_ARB_EN
    .mem_req     (mem_req),
    .mem_gnt     (gnt),
`endif
    .done        (done)
  );

`ifndef HAMMING_SEQ_MEM_ARB_EN
  assign mem_req = 1'b0;
`endif

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  // Memory model plus granted-cycle and write-strobe counters.
  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
    if (mem_wr_en) strobes <= strobes + 1;
    if (reset) g <= 0;
    else if (gnt && g < TOT) g <= g + 1;
  end

`ifdef HAMMING_SEQ_MEM_ARB_EN
  // Grant pattern 1,0,0,1 repeating.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      gnt = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end
  end
`endif

  function automatic logic [15:0] ham(input logic [10:0] d);
    logic [15:0] cw;
    int k;
    logic x;
    cw = 16'h0000;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int p = 1; p < 16; p++) if (p[b]) x = x ^ cw[p];
      cw[1 << b] = x;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT port against the model.
  task automatic compare();
    int m, ph, base;
    logic [15:0] cw;
    if (reset) begin
      chk("rst_addr", mem_addr, SRC);
      chk("rst_we", mem_wr_en, 0);
    end else if (g < TOT) begin
      m = g / 4;
      ph = g % 4;
      base = (ph < 2) ? SRC : DST;
      chk("addr", mem_addr, (base + 2 * m + (ph % 2)) % 256);
      chk("we", mem_wr_en, (ph >= 2) && gnt);
      chk("done_early", done, 0);
`ifdef HAMMING_SEQ_MEM_ARB_EN
      chk("req", mem_req, 1);
`endif
      if (ph >= 2) begin
        cw = ham(msg[m]);
        chk("wdata", mem_wr_data, (ph == 2) ? cw[7:0] : cw[15:8]);
      end
    end else begin
      chk("fin_addr", mem_addr, DST);
      chk("fin_we", mem_wr_en, 0);
      chk("fin_done", done, 1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    #2;
  endtask

  task automatic set_msg(input int i, input logic [7:0] lo, input logic [7:0] hi);
    img[SRC + 2 * i]     = lo;
    img[SRC + 2 * i + 1] = hi;
    msg[i] = {hi[2:0], lo};
  endtask

  task automatic fill_dst();
    for (int i = 0; i < 2 * N; i++) img[DST + i] = 8'h5A;
  endtask

  task automatic run(input int abort_at);
    int edges, base_str, ab;
    logic [15:0] cw;
    ab = abort_at;
    reset = 1'b1;
    ld_en = 1'b1;
    cycle();
    ld_en = 1'b0;
    cycle();
    base_str = strobes;
    reset = 1'b0;
    edges = 0;
    while (!done && edges < 400) begin
      cycle();
      edges++;
      if (ab > 0 && edges == ab) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        base_str = strobes;
        edges = 0;
        ab = 0;
      end
    end
    chk("done_timeout", done, 1);
`ifdef HAMMING_SEQ_MEM_ARB_EN
    chk("done_gnt_cycles", g, TOT);
`else
    chk("done_edge", edges, TOT);
`endif
    cycle();
    cycle();
    chk("strobes", strobes - base_str, 2 * N);
    for (int i = 0; i < N; i++) begin
      cw = ham(msg[i]);
      chk("dst_lo", mem[DST + 2 * i], cw[7:0]);
      chk("dst_hi", mem[DST + 2 * i + 1], cw[15:8]);
      chk("src_lo", mem[SRC + 2 * i], img[SRC + 2 * i]);
      chk("src_hi", mem[SRC + 2 * i + 1], img[SRC + 2 * i + 1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;

    // Pin the reference codeword builder to hand-computed values.
    chk("ham_7ff", ham(11'h7FF), 16'hFFFF);
    chk("ham_001", ham(11'h001), 16'h000F);
    chk("ham_400", ham(11'h400), 16'h8117);
    chk("ham_000", ham(11'h000), 16'h0000);

    // All-zero messages.
    for (int i = 0; i < N; i++) set_msg(i, 8'h00, 8'h00);
    fill_dst();
    run(0);
    for (int i = 0; i < 2 * N; i++) chk("zero_dst", mem[DST + i], 8'h00);

    // Directed corner messages, including garbage in the high byte.
    for (int i = 0; i < N; i++) set_msg(i, 8'($urandom), 8'($urandom));
    set_msg(0, 8'hFF, 8'h07);
    set_msg(1, 8'h01, 8'h00);
    set_msg(2, 8'h00, 8'h04);
    set_msg(3, 8'h00, 8'hFC);
    fill_dst();
    run(0);
    chk("lit_7ff_lo", mem[DST + 0], 8'hFF);
    chk("lit_7ff_hi", mem[DST + 1], 8'hFF);
    chk("lit_001_lo", mem[DST + 2], 8'h0F);
    chk("lit_001_hi", mem[DST + 3], 8'h00);
    chk("lit_400_lo", mem[DST + 4], 8'h17);
    chk("lit_400_hi", mem[DST + 5], 8'h81);
    chk("lit_fc_lo", mem[DST + 6], 8'h17);
    chk("lit_fc_hi", mem[DST + 7], 8'h81);

    // Fully random messages.
    for (int i = 0; i < N; i++) set_msg(i, 8'($urandom), 8'($urandom));
    fill_dst();
    run(0);

    // Same random data, reset pulsed on the 23rd edge of the run.
    fill_dst();
    run(22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_enc_seq.md
Name: hamming_enc_seq

Overview:
- Hardware sequencer that runs the program-1 Hamming SECDED (16,11) encode job over data memory without the instruction core.
- Walks NUM_MSG 11-bit messages stored as byte pairs from SRC_BASE and computes p8/p4/p2/p1/p0.
- Writes the 16-bit encoded words as byte pairs from DST_BASE.
- Owns the single data-memory port while running and raises done when finished; sits beside dm1 under top_level.

Parameters:
- NUM_MSG, 15: number of messages processed per run.
- SRC_BASE, 0: byte address of the first source message (low byte).
- DST_BASE, 30: byte address of the first encoded output (low byte).
- AW, 8: data-memory address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; also acts as the start request.
- mem_addr  out  AW  data-memory byte address.
- mem_rd_data  in  8  data-memory read data; combinational read of mem_addr in the same cycle.
- mem_wr_en  out  1  write strobe; memory writes mem_wr_data at mem_addr on the rising edge.
- mem_wr_data  out  8  write data.
- done  out  1  high once all NUM_MSG outputs are written.

Behaviour:
- States: RD_LO, RD_HI, WR_LO, WR_HI, FIN. Message index idx is 4 bits (wide enough for NUM_MSG-1). Capture registers: lo_q[7:0], hi_q[2:0].
- Reset (synchronous, while high): state=RD_LO, idx=0, done=0, mem_wr_en=0. While reset is high, mem_addr=SRC_BASE and no write occurs.
- RD_LO: mem_addr=SRC_BASE+2*idx; capture lo_q=mem_rd_data (d[8:1]); go to RD_HI.
- RD_HI: mem_addr=SRC_BASE+2*idx+1; capture hi_q=mem_rd_data[2:0] (d[11:9]); bits [7:3] are ignored. Go to WR_LO.
- Parity, combinational from d={hi_q,lo_q}:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1]^p8^p4^p2^p1
- WR_LO: mem_addr=DST_BASE+2*idx; mem_wr_en=1; mem_wr_data={d[4:2],p4,d1,p2,p1,p0}. Go to WR_HI.
- WR_HI: mem_addr=DST_BASE+2*idx+1; mem_wr_en=1; mem_wr_data={d[11:5],p8}.
  - If idx==NUM_MSG-1: go to FIN.
  - Otherwise: idx+1, go to RD_LO.
- FIN: done=1 (registered), mem_wr_en=0, mem_addr holds DST_BASE. Stays in FIN until reset.
- Outputs are combinational from state, except done, which is registered.
- Address arithmetic is modulo 2^AW. Source and destination regions must not overlap; overlap behaviour is undefined.
- Latency: exactly 4 cycles per message. done rises after the 4*NUM_MSG-th rising edge with reset low (edge 60 at defaults).
- mem_wr_en is asserted on exactly 2*NUM_MSG edges per run.
- Reset mid-run aborts immediately and restarts from idx=0 after deassertion. Bytes already written are not restored.
- Reset asserted while in FIN clears done on the next edge.

Optional Feature:
- Macro HAMMING_SEQ_MEM_ARB_EN shares the memory port with another requester.
- With it defined, two ports are added:
  - mem_req out 1: high in RD_LO/RD_HI/WR_LO/WR_HI.
  - mem_gnt in 1: grant from the arbiter.
- A state advances and captures data, and mem_wr_en is asserted, only in cycles where mem_gnt=1. With mem_gnt=0, the state, idx and capture registers hold and mem_wr_en=0.
- Latency becomes 4*NUM_MSG granted cycles.
- Without the macro, neither port exists and the block behaves as if mem_gnt were constantly 1.

Test Plan:
- All 15 messages = 0 (src bytes 0x00/0x00): every destination pair = 0x00/0x00; done high after edge 60 and not before.
- Message 11'h7FF (lo=0xFF, hi=0x07): output 16'hFFFF; bytes [DST]=0xFF, [DST+1]=0xFF.
- Message 11'h001 (lo=0x01, hi=0x00): output 16'h000F. Message 11'h400 (lo=0x00, hi=0x04): output 16'h8117. Also check that hi-byte garbage 0xFC on message 11'h400 still yields 16'h8117.
- 15 random messages versus the parity equations above: all 30 destination bytes match; exactly 30 write strobes; source bytes unchanged.
- Reset pulsed at edge 23 mid-run: done stays 0 and the run restarts at idx 0. Final memory matches the clean run; done rises 60 edges after the second deassertion.
- HAMMING_SEQ_MEM_ARB_EN defined, mem_gnt toggled 1,0,0,1 repeating: outputs match the clean run; no write while mem_gnt=0; done after 60 granted cycles.
